mul_partial_seq: RTL and testbench

Parametrised sequential truncated multiplier; successor to the 2-bit combinational partial multiplier.
Computes only the low OUT_WIDTH bits of A*B using one shift-add step per clock, under a valid/ready handshake on both input and output.
Used in PIM datapaths where only the low product bits are consumed and area matters more than latency.

---
 rtl/mul_pkg.sv | 13 +
 rtl/adder_nbit.sv | 14 +
 rtl/mul_partial_seq.sv | 110 +++++++++++
 tb/tb_mul_partial_seq.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared types and sizing helpers for the sequential truncated multiplier family.
package mul_pkg;

  localparam int MUL_WIDTH_DEF = 8;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Counter must hold 0..WIDTH.
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/adder_nbit.sv
// Plain N-bit ripple adder with carry in/out.
module adder_nbit #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

endmodule

// File: rtl/mul_partial_seq.sv
// Shift-add multiplier keeping only the low OUT_WIDTH product bits, one bit per clock.
// Define MUL_PARTIAL_EARLY_EXIT_EN to finish as soon as the remaining work is zero.
module mul_partial_seq import mul_pkg::*; #(
  parameter int WIDTH     = MUL_WIDTH_DEF,
  parameter int OUT_WIDTH = WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] P,
  output logic                 busy
);

  localparam int CW = cnt_w(WIDTH);

  state_t               state, nstate;
  logic [OUT_WIDTH-1:0] mcand, acc, p_q, sum, mcand_init, acc_nxt, mcand_nxt;
  logic [WIDTH-1:0]     mplier, mplier_nxt;
  logic [CW-1:0]        cnt;
  logic                 last, cout_unused;

  // Upper A bits beyond OUT_WIDTH can never reach the retained product.
  generate
    if (OUT_WIDTH >= WIDTH) begin : g_ext
      assign mcand_init = OUT_WIDTH'(A);
    end else begin : g_trunc
      assign mcand_init = A[OUT_WIDTH-1:0];
    end
  endgenerate

  adder_nbit #(.N(OUT_WIDTH)) u_add (
    .a   (acc),
    .b   (mcand),
    .cin (1'b0),
    .sum (sum),
    .cout(cout_unused)
  );

  assign acc_nxt    = mplier[0] ? sum : acc;
  assign mcand_nxt  = mcand << 1;
  assign mplier_nxt = mplier >> 1;

`ifdef MUL_PARTIAL_EARLY_EXIT_EN
  assign last = (cnt == CW'(WIDTH - 1)) || (mplier_nxt == '0) || (mcand_nxt == '0);
`else
  assign last = (cnt == CW'(WIDTH - 1));
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (in_valid) nstate = RUN;
      RUN:     if (last)     nstate = DONE;
      DONE:    if (out_ready) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      RUN:     busy      = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      p_q    <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          mcand  <= mcand_init;
          mplier <= B;
          acc    <= '0;
          cnt    <= '0;
        end
        RUN: begin
          acc    <= acc_nxt;
          mcand  <= mcand_nxt;
          mplier <= mplier_nxt;
          cnt    <= cnt + CW'(1);
          if (last) p_q <= acc_nxt;
        end
        default: ;
      endcase
    end
  end

  assign P = p_q;

endmodule

// File: tb/tb_mul_partial_seq.sv
// Self-checking bench for mul_partial_seq across four width configurations.
module tb_mul_partial_seq;

`ifdef MUL_PARTIAL_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic       clk, rst;
  logic       iv[4], ordy[4];
  logic       ir[4], ov[4], bz[4];
  logic [7:0] av[4], bv[4];
  logic [1:0]  p0;
  logic [7:0]  p1;
  logic [15:0] p2;
  logic [3:0]  p3;

  int n_assert = 0;
  int n_fail   = 0;

  mul_partial_seq #(.WIDTH(2), .OUT_WIDTH(2)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .A(av[0][1:0]), .B(bv[0][1:0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .P(p0), .busy(bz[0]));
  mul_partial_seq #(.WIDTH(8), .OUT_WIDTH(8)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .A(av[1]), .B(bv[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .P(p1), .busy(bz[1]));
  mul_partial_seq #(.WIDTH(8), .OUT_WIDTH(16)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .A(av[2]), .B(bv[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .P(p2), .busy(bz[2]));
  mul_partial_seq #(.WIDTH(8), .OUT_WIDTH(4)) dut3 (
    .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]), .A(av[3]), .B(bv[3]),
    .out_valid(ov[3]), .out_ready(ordy[3]), .P(p3), .busy(bz[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wof(input int d);
    return (d == 0) ? 2 : 8;
  endfunction

  function automatic int oof(input int d);
    case (d)
      0: return 2;
      1: return 8;
      2: return 16;
      default: return 4;
    endcase
  endfunction

  function automatic logic [63:0] getp(input int d);
    case (d)
      0: return 64'(p0);
      1: return 64'(p1);
      2: return 64'(p2);
      default: return 64'(p3);
    endcase
  endfunction

  function automatic longint mask(input int o);
    return (longint'(1) << o) - 1;
  endfunction

  // Edges from acceptance to out_valid: fixed WIDTH, or earliest point where nothing is left to add.
  function automatic int exp_lat(input int w, input int o, input longint a, input longint b);
    longint m = a & mask(o);
    int k_first = w;
    for (int k = w - 1; k >= 1; k--)
      if (((b >> k) == 0) || (((m << k) & mask(o)) == 0)) k_first = k;
    return EARLY ? k_first : w;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run_op(input int d, input longint a, input longint b, input int hold);
    int     w, o, el, n;
    longint ep;
    w  = wof(d);
    o  = oof(d);
    ep = (a * b) & mask(o);
    el = exp_lat(w, o, a, b);
    chk("idle_in_ready", 64'(ir[d]), 64'd1);
    av[d] = 8'(a); bv[d] = 8'(b); iv[d] = 1'b1;
    @(posedge clk); #1;
    iv[d] = 1'b0;
    av[d] = 8'($urandom); bv[d] = 8'($urandom);
    chk("run_busy", 64'(bz[d]), 64'd1);
    chk("run_in_ready", 64'(ir[d]), 64'd0);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (ov[d] !== 1'b1 && n < 40);
    chk("latency", 64'(n), 64'(el));
    chk("product", getp(d), 64'(ep));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_out_valid", 64'(ov[d]), 64'd1);
      chk("hold_product", getp(d), 64'(ep));
      chk("hold_in_ready", 64'(ir[d]), 64'd0);
    end
    // Offer a new operand in the consuming cycle; it must not be taken.
    ordy[d] = 1'b1; iv[d] = 1'b1;
    @(posedge clk); #1;
    ordy[d] = 1'b0; iv[d] = 1'b0;
    chk("drain_out_valid", 64'(ov[d]), 64'd0);
    chk("drain_in_ready", 64'(ir[d]), 64'd1);
    chk("drain_busy", 64'(bz[d]), 64'd0);
    chk("drain_p_kept", getp(d), 64'(ep));
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 4; d++) begin
      iv[d] = 1'b0; ordy[d] = 1'b0; av[d] = '0; bv[d] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      chk("rst_in_ready", 64'(ir[d]), 64'd1);
      chk("rst_out_valid", 64'(ov[d]), 64'd0);
      chk("rst_busy", 64'(bz[d]), 64'd0);
      chk("rst_p", getp(d), 64'd0);
    end
    rst = 1'b0;

    // 2x2 partial multiplier, all pairs
    run_op(0, 3, 3, 0);
    run_op(0, 2, 1, 0);
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        run_op(0, a, b, 0);

    // 8x8 low byte, with 5-cycle backpressure
    run_op(1, 200, 3, 5);
    run_op(1, 5, 1, 0);
    run_op(1, 255, 255, 1);
    run_op(1, 128, 2, 0);

    // Reset on the third RUN edge aborts the operation
    av[1] = 8'd201; bv[1] = 8'd255; iv[1] = 1'b1;
    @(posedge clk); #1;
    iv[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_in_ready", 64'(ir[1]), 64'd1);
    chk("abort_out_valid", 64'(ov[1]), 64'd0);
    chk("abort_busy", 64'(bz[1]), 64'd0);
    chk("abort_p", getp(1), 64'd0);
    run_op(1, 200, 3, 0);

    // Full 16-bit product
    run_op(2, 255, 255, 2);
    run_op(2, 0, 77, 0);
    run_op(2, 77, 0, 0);

    // 4-bit truncation: upper A bits irrelevant
    run_op(3, 8'hF3, 8'h07, 0);
    run_op(3, 8'h03, 8'h07, 0);
    run_op(3, 8'h10, 8'hFF, 0);

    for (int i = 0; i < 20; i++) begin
      run_op(1, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 3));
      run_op(2, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 3));
      run_op(3, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
